// File: rtl/pc_display.sv
`default_nettype none
// ============================================================================
// Module      : pc_display
// Description : Captures the CPU program counter on a valid strobe and shows
//               one 16-bit half of it as four hex digits on a multiplexed,
//               active-low seven-segment display. The displayed value is only
//               refreshed on frame boundaries, so a scan never mixes two
//               values. An 8-bit capture counter aids lab debug.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCAN_DIV  : fast_clk cycles per digit slot (2..65535)
// Ports
//   fast_clk  in   1  system clock, rising edge
//   reset     in   1  synchronous, active-low reset
//   pc_in     in  32  program counter from the CPU
//   pc_valid  in   1  capture strobe (level; one capture per high cycle)
//   hold      in   1  suppresses captures when 1
//   half_sel  in   1  0 = show bits [15:0], 1 = show bits [31:16]
//   an        out  4  digit enables, active-low, digit 0 rightmost
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1  decimal point, active-low
//   cap_count out  8  accepted captures, modulo 256
// ============================================================================
module pc_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic        fast_clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  input  logic        hold,
  input  logic        half_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  cap_count
);

  localparam logic [15:0] c_PRE_LAST = 16'(SCAN_DIV - 1);

  logic [31:0] r_pc_q;
  logic [15:0] r_snap;
  logic        r_snap_hi;
  logic [15:0] r_pre;
  logic [1:0]  r_dig;
  logic [7:0]  r_cap_count;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_capture;
  logic        w_slot_end;
  logic        w_boundary;
  logic [3:0]  w_nibble;
  logic [6:0]  w_hex;

  assign w_capture  = pc_valid & ~hold;
  assign w_slot_end = (r_pre == c_PRE_LAST);
  assign w_boundary = w_slot_end & (r_dig == 2'd3);

  // Nibble of the frame snapshot belonging to the digit being scanned.
  always_comb begin
    w_nibble = r_snap[3:0];
    case (r_dig)
      2'd0: w_nibble = r_snap[3:0];
      2'd1: w_nibble = r_snap[7:4];
      2'd2: w_nibble = r_snap[11:8];
      2'd3: w_nibble = r_snap[15:12];
      default: w_nibble = r_snap[3:0];
    endcase
  end

  // Active-low hex decode, {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  always_comb begin
    w_hex = 7'b1111111;
    case (w_nibble)
      4'h0: w_hex = 7'b1000000;
      4'h1: w_hex = 7'b1111001;
      4'h2: w_hex = 7'b0100100;
      4'h3: w_hex = 7'b0110000;
      4'h4: w_hex = 7'b0011001;
      4'h5: w_hex = 7'b0010010;
      4'h6: w_hex = 7'b0000010;
      4'h7: w_hex = 7'b1111000;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0010000;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b0000011;
      4'hC: w_hex = 7'b1000110;
      4'hD: w_hex = 7'b0100001;
      4'hE: w_hex = 7'b0000110;
      4'hF: w_hex = 7'b0001110;
      default: w_hex = 7'b1111111;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (!reset) begin
      r_pc_q      <= 32'h0;
      r_snap      <= 16'h0;
      r_snap_hi   <= 1'b0;
      r_pre       <= 16'h0;
      r_dig       <= 2'd0;
      r_cap_count <= 8'h0;
      r_an        <= 4'b1111;
      r_seg       <= 7'b1111111;
      r_dp        <= 1'b1;
    end else begin
      if (w_capture) begin
        r_pc_q      <= pc_in;
        r_cap_count <= r_cap_count + 8'd1;
      end

      if (w_slot_end) begin
        r_pre <= 16'h0;
        r_dig <= r_dig + 2'd1;
      end else begin
        r_pre <= r_pre + 16'd1;
      end

      // Snapshot reads the pre-edge r_pc_q, so a capture landing on the
      // boundary edge is only shown one frame later.
      if (w_boundary) begin
        r_snap    <= half_sel ? r_pc_q[31:16] : r_pc_q[15:0];
        r_snap_hi <= half_sel;
      end

      // First cycle of each slot is blanked to avoid ghosting between digits.
      if (r_pre == 16'h0) begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_dig);
        r_seg <= w_hex;
        r_dp  <= ~((r_dig == 2'd3) & r_snap_hi);
      end
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign cap_count = r_cap_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_display
// Description : Self-checking bench for pc_display (SCAN_DIV = 4). Stimulus
//               pushes hand-derived expected outputs into a scoreboard queue;
//               a monitor pops and compares one entry per output update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_display;

  localparam int SD = 4;

  logic        fast_clk = 1'b0;
  logic        reset    = 1'b0;
  logic [31:0] pc_in    = 32'h0;
  logic        pc_valid = 1'b0;
  logic        hold     = 1'b0;
  logic        half_sel = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  cap_count;

  pc_display #(.SCAN_DIV(SD)) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .hold      (hold),
    .half_sel  (half_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .cap_count (cap_count)
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] e_cnt = 8'h0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Monitor: one output update per clock, sampled on the falling edge.
  always @(negedge fast_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || cap_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got an=%b seg=%b dp=%b cnt=%0d, required an=%b seg=%b dp=%b cnt=%0d",
                 e.name, an, seg, dp, cap_count, e.an, e.seg, e.dp, e.cnt);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic [7:0] c);
    exp_t e;
    e.name = nm; e.an = a; e.seg = s; e.dp = d; e.cnt = c;
    q.push_back(e);
  endtask

  // Runs n_ticks cycles starting at slot 0 / blank cycle, expecting the frame
  // snapshot v (hi = upper half shown). Strobes pc_valid with s_val on tick
  // indices s_at .. s_at+s_len-1.
  task automatic run_frame(input string nm, input logic [15:0] v, input logic hi,
                           input int n_ticks, input int s_at, input int s_len,
                           input logic [31:0] s_val);
    for (int i = 0; i < n_ticks; i++) begin
      int s, j;
      logic strobe;
      strobe   = (i >= s_at) && (i < s_at + s_len);
      pc_valid = strobe;
      pc_in    = s_val;
      @(posedge fast_clk);
      #1;
      if (strobe && !hold) e_cnt = e_cnt + 8'd1;
      s = i / SD;
      j = i % SD;
      if (j == 0)
        push_exp(nm, 4'b1111, 7'b1111111, 1'b1, e_cnt);
      else
        push_exp(nm, ~(4'b0001 << s), hex7(v[4*s +: 4]), !(s == 3 && hi), e_cnt);
    end
    pc_valid = 1'b0;
  endtask

  initial begin
    // Reset with a strobe pending: nothing may be captured.
    reset = 1'b0; pc_valid = 1'b1; pc_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge fast_clk); #1;
      push_exp("reset", 4'b1111, 7'b1111111, 1'b1, 8'd0);
    end
    reset = 1'b1; pc_valid = 1'b0;

    run_frame("after_reset", 16'h0000, 1'b0, 16, 2, 1, 32'h0000_1234);
    run_frame("low_half_tear", 16'h1234, 1'b0, 16, 5, 1, 32'h0000_5555);
    run_frame("new_frame_5555", 16'h5555, 1'b0, 16, 15, 1, 32'h0000_000F);
    run_frame("boundary_old", 16'h5555, 1'b0, 16, -1, 0, 32'h0);
    half_sel = 1'b1;
    run_frame("boundary_new", 16'h000F, 1'b0, 16, 1, 1, 32'hABCD_0000);
    hold = 1'b1;
    run_frame("high_half_hold", 16'hABCD, 1'b1, 16, 3, 10, 32'h1234_5678);
    hold = 1'b0;
    half_sel = 1'b0;
    run_frame("hold_kept", 16'hABCD, 1'b1, 16, 0, 16, 32'h0000_1234);
    for (int f = 0; f < 15; f++)
      run_frame("count_wrap", 16'h1234, 1'b0, 16, 0, 16, 32'h0000_1234);
    run_frame("pre_mid_reset", 16'h1234, 1'b0, 6, -1, 0, 32'h0);

    // Mid-frame reset, again with a coincident strobe.
    reset = 1'b0; pc_valid = 1'b1; pc_in = 32'hFFFF_FFFF;
    @(posedge fast_clk); #1;
    e_cnt = 8'd0;
    push_exp("mid_reset", 4'b1111, 7'b1111111, 1'b1, 8'd0);
    reset = 1'b1; pc_valid = 1'b0;
    run_frame("post_mid_reset", 16'h0000, 1'b0, 16, -1, 0, 32'h0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge fast_clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
